// File: rtl/ra_fill_ctrl_if.sv
// Bus bundle between the RA fill controller and its neighbours: tile request/publish,
// DRAM burst read, and the ping-pong buffer write port.
interface ra_fill_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int W      = 16,
  parameter int H      = 16,
  parameter int ADDR_W = 32
);
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int LW   = $clog2(NPIX + 1);

  logic              tile_req;
  logic [ADDR_W-1:0] tile_base;
  logic              tile_req_ready;
  logic              dram_cmd_valid;
  logic              dram_cmd_ready;
  logic [ADDR_W-1:0] dram_cmd_addr;
  logic [LW-1:0]     dram_cmd_len;
  logic              dram_rvalid;
  logic              dram_rready;
  logic [DATA_W-1:0] dram_rdata;
  logic              ra_start_fill;
  logic              ra_wr_en;
  logic [AW-1:0]     ra_wr_addr;
  logic [DATA_W-1:0] ra_wr_data;
  logic              tile_valid;
  logic              tile_release;
  logic              busy;

  modport master (
    input  tile_req, tile_base, dram_cmd_ready, dram_rvalid, dram_rdata, tile_release,
    output tile_req_ready, dram_cmd_valid, dram_cmd_addr, dram_cmd_len, dram_rready,
           ra_start_fill, ra_wr_en, ra_wr_addr, ra_wr_data, tile_valid, busy
  );

  modport slave (
    output tile_req, tile_base, dram_cmd_ready, dram_rvalid, dram_rdata, tile_release,
    input  tile_req_ready, dram_cmd_valid, dram_cmd_addr, dram_cmd_len, dram_rready,
           ra_start_fill, ra_wr_en, ra_wr_addr, ra_wr_data, tile_valid, busy
  );
endinterface

// File: rtl/ra_fill_ctrl.sv
// Write-side controller for the RA0/RA1 ping-pong buffer: one DRAM burst per tile,
// raster-order writes into the write bank, then a bank swap once the consumer frees the read bank.
//
// state  | meaning
// IDLE   | waiting for tile_req; only state that accepts a request
// CMD    | burst read command held on the DRAM command port
// FILL   | accepting read beats, writing buffer by beat index
// PUB    | tile complete, waiting for the read bank to be free
// SWAP   | one-cycle bank swap pulse, tile becomes visible
module ra_fill_ctrl #(
  parameter int DATA_W = 16,
  parameter int W      = 16,
  parameter int H      = 16,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  ra_fill_ctrl_if.master bus
);
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int LW   = $clog2(NPIX + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_FILL, S_PUB, S_SWAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_tile_valid, w_tile_valid_nxt;
  logic              w_beat, w_last, w_pub_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_tile_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tile_valid <= w_tile_valid_nxt;
      if (r_state == S_IDLE && bus.tile_req) r_addr <= bus.tile_base;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_tile_valid_nxt = r_tile_valid;
    w_beat   = (r_state == S_FILL) && bus.dram_rvalid;
    w_last   = w_beat && (r_cnt == AW'(NPIX - 1));
    w_pub_go = (r_state == S_PUB) && (!r_tile_valid || bus.tile_release);

    case (r_state)
      S_IDLE: if (bus.tile_req)       w_state_nxt = S_CMD;
      S_CMD:  if (bus.dram_cmd_ready) w_state_nxt = S_FILL;
      S_FILL: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PUB;
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PUB:  if (w_pub_go) w_state_nxt = S_SWAP;
      S_SWAP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A release that lets PUB exit is absorbed by the swap: the new tile keeps tile_valid high.
    if (r_state == S_SWAP)
      w_tile_valid_nxt = 1'b1;
    else if (bus.tile_release && !w_pub_go)
      w_tile_valid_nxt = 1'b0;
  end

  assign bus.tile_req_ready = (r_state == S_IDLE);
  assign bus.dram_cmd_valid = (r_state == S_CMD);
  assign bus.dram_cmd_addr  = r_addr;
  assign bus.dram_cmd_len   = LW'(NPIX);
  assign bus.dram_rready    = (r_state == S_FILL);
  assign bus.ra_wr_en       = w_beat;
  assign bus.ra_wr_addr     = r_cnt;
  assign bus.ra_wr_data     = bus.dram_rdata;
  assign bus.ra_start_fill  = (r_state == S_SWAP);
  assign bus.tile_valid     = r_tile_valid;
  assign bus.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_ra_fill_ctrl.sv
// Directed bench for ra_fill_ctrl: scoreboard of expected buffer writes plus a small ping-pong buffer model.
module tb_ra_fill_ctrl;
  localparam int NPIX = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;
  exp_t q[$];

  logic        wb;
  logic [15:0] mem [0:1][0:255];

  ra_fill_ctrl_if #(.DATA_W(16), .W(16), .H(16), .ADDR_W(32)) bus ();

  ra_fill_ctrl #(.DATA_W(16), .W(16), .H(16), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ping-pong buffer model sharing the controller's reset: write bank 0 after reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb <= 1'b0;
    else if (bus.ra_start_fill) wb <= ~wb;
    else if (bus.ra_wr_en) mem[wb][bus.ra_wr_addr] <= bus.ra_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input logic [15:0] seed, input int gap,
                      input int hold, input bit swap, input bit req_busy, input int abort_at);
    int   i;
    int   nw;
    bit   v;
    exp_t e;
    cyc();
    bus.tile_req = 1'b1;
    bus.tile_base = base;
    #3 chk("req_ready", bus.tile_req_ready, 1);
    cyc();
    bus.tile_req = req_busy;
    bus.tile_base = 32'h9999;
    #3;
    chk("cmd_valid", bus.dram_cmd_valid, 1);
    chk("cmd_addr", bus.dram_cmd_addr, base);
    chk("cmd_len", bus.dram_cmd_len, NPIX);
    chk("ready_busy", bus.tile_req_ready, 0);
    chk("busy", bus.busy, 1);
    for (int h = 0; h < hold; h++) begin
      cyc();
      #3;
      chk("hold_valid", bus.dram_cmd_valid, 1);
      chk("hold_addr", bus.dram_cmd_addr, base);
      chk("hold_rready", bus.dram_rready, 0);
      chk("hold_wr", bus.ra_wr_en, 0);
    end
    cyc();
    bus.dram_cmd_ready = 1'b1;
    #3 chk("hs_valid", bus.dram_cmd_valid, 1);
    i = 0;
    nw = 0;
    while (i < NPIX) begin
      cyc();
      bus.dram_cmd_ready = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        bus.dram_rvalid = 1'b0;
        bus.tile_req = 1'b0;
        #3;
        chk("rst_wr", bus.ra_wr_en, 0);
        chk("rst_rready", bus.dram_rready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd", bus.dram_cmd_valid, 0);
        chk("rst_addr", bus.dram_cmd_addr, 0);
        chk("rst_tv", bus.tile_valid, 0);
        chk("rst_sf", bus.ra_start_fill, 0);
        q.delete();
        cyc();
        rst_n = 1'b1;
        return;
      end
      v = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      bus.dram_rvalid = v;
      bus.dram_rdata = seed + 16'(i);
      if (v) q.push_back({8'(i), seed + 16'(i)});
      #3;
      chk("rready", bus.dram_rready, 1);
      chk("wr_en", bus.ra_wr_en, v);
      if (bus.ra_wr_en) begin
        nw++;
        if (q.size() == 0) chk("spurious_wr", 1, 0);
        else begin
          e = q.pop_front();
          chk("wr_addr", bus.ra_wr_addr, e.a);
          chk("wr_data", bus.ra_wr_data, e.d);
        end
      end
      if (v) i++;
    end
    cyc();
    bus.dram_rvalid = 1'b0;
    bus.tile_req = 1'b0;
    #3;
    chk("pub_sf", bus.ra_start_fill, 0);
    chk("pub_wr", bus.ra_wr_en, 0);
    chk("pub_rready", bus.dram_rready, 0);
    chk("pub_busy", bus.busy, 1);
    chk("nwrites", nw, NPIX);
    if (swap) begin
      cyc();
      #3;
      chk("swap_sf", bus.ra_start_fill, 1);
      chk("swap_wr", bus.ra_wr_en, 0);
      cyc();
      #3;
      chk("post_sf", bus.ra_start_fill, 0);
      chk("post_tv", bus.tile_valid, 1);
      chk("post_ready", bus.tile_req_ready, 1);
      chk("post_addr", bus.dram_cmd_addr, base);
      chk("post_cmd", bus.dram_cmd_valid, 0);
      chk("rd37", mem[~wb][37], seed + 16'd37);
    end
  endtask

  task automatic release_tile(input logic exp_tv);
    cyc();
    bus.tile_release = 1'b1;
    #3;
    cyc();
    bus.tile_release = 1'b0;
    #3;
    chk("rel_tv", bus.tile_valid, exp_tv);
    chk("rel_busy", bus.busy, 0);
  endtask

  initial begin
    bus.tile_req = 1'b0;
    bus.tile_base = '0;
    bus.dram_cmd_ready = 1'b0;
    bus.dram_rvalid = 1'b0;
    bus.dram_rdata = '0;
    bus.tile_release = 1'b0;
    repeat (3) cyc();
    #3;
    chk("rst_ready", bus.tile_req_ready, 1);
    chk("rst_busy0", bus.busy, 0);
    chk("rst_cmd0", bus.dram_cmd_valid, 0);
    chk("rst_rready0", bus.dram_rready, 0);
    chk("rst_wr0", bus.ra_wr_en, 0);
    chk("rst_sf0", bus.ra_start_fill, 0);
    chk("rst_tv0", bus.tile_valid, 0);
    chk("rst_addr0", bus.dram_cmd_addr, 0);
    cyc();
    rst_n = 1'b1;

    fill(32'h1000, 16'h0000, 0, 0, 1'b1, 1'b0, -1);
    release_tile(1'b0);
    fill(32'h3000, 16'h0100, 0, 10, 1'b1, 1'b0, -1);
    release_tile(1'b0);
    fill(32'h4000, 16'h2000, 50, 2, 1'b1, 1'b0, -1);

    // Second tile with the first still owned: must park in PUB until release.
    fill(32'h2000, 16'hB000, 20, 0, 1'b0, 1'b0, -1);
    repeat (5) begin
      cyc();
      #3;
      chk("park_sf", bus.ra_start_fill, 0);
      chk("park_busy", bus.busy, 1);
      chk("park_tv", bus.tile_valid, 1);
      chk("park_rd37", mem[~wb][37], 16'h2000 + 16'd37);
    end
    cyc();
    bus.tile_release = 1'b1;
    #3 chk("relpub_sf", bus.ra_start_fill, 0);
    cyc();
    bus.tile_release = 1'b0;
    #3;
    chk("relpub_swap", bus.ra_start_fill, 1);
    chk("relpub_tv", bus.tile_valid, 1);
    cyc();
    #3;
    chk("relpub_tv2", bus.tile_valid, 1);
    chk("relpub_sf2", bus.ra_start_fill, 0);
    chk("relpub_rd37", mem[~wb][37], 16'hB000 + 16'd37);

    release_tile(1'b0);
    release_tile(1'b0);
    fill(32'h5000, 16'h5000, 0, 3, 1'b1, 1'b1, -1);

    fill(32'h6000, 16'h6000, 0, 0, 1'b0, 1'b0, 100);
    fill(32'h7000, 16'h7000, 0, 0, 1'b1, 1'b0, -1);
    chk("after_rst_bank", wb, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
